// File: rtl/fft_frame_writer.sv
// fft_frame_writer: overlapped N_FFT-sample frame producer (history replay + HOP new samples); FFT_FRAME_WRITER_PREEMPH_EN adds pre-emphasis.
module fft_frame_writer #(
  parameter int N_FFT      = 256,
  parameter int HOP        = 128,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_en_inf_system_sync,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  buf_almost_wfull,
  input  logic                  buf_wfull,
  output logic                  w_req,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  frame_start,
  output logic                  overflow
);
  localparam int HIST = N_FFT - HOP;
  localparam int AW   = (HIST > 1) ? $clog2(HIST) : 1;
  localparam int CW   = $clog2(N_FFT + 1);

  typedef enum logic [1:0] {IDLE, PRIME, REPLAY, STREAM} state_t;
  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] ring [HIST];
  logic [DATA_WIDTH-1:0] pend_d, cap_d;
  logic [AW-1:0]         wp, ra;
  logic [CW-1:0]         cnt;
  logic [CW:0]           rsum;
  logic                  pend_v, issue, consume, rd_en, adv, last, take;

`ifdef FFT_FRAME_WRITER_PREEMPH_EN
  localparam logic signed [DATA_WIDTH+1:0] SMAX = (DATA_WIDTH+2)'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [DATA_WIDTH+1:0] SMIN = -(DATA_WIDTH+2)'(2 ** (DATA_WIDTH - 1));
  logic [DATA_WIDTH-1:0]          xp;
  logic signed [DATA_WIDTH+1:0]   xe, ye;
  always_comb begin
    xe    = $signed({{2{xp[DATA_WIDTH-1]}}, xp});
    ye    = $signed({{2{sample_in[DATA_WIDTH-1]}}, sample_in}) - (xe - (xe >>> 5));
    cap_d = (ye > SMAX) ? SMAX[DATA_WIDTH-1:0] : (ye < SMIN) ? SMIN[DATA_WIDTH-1:0] : ye[DATA_WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) xp <= '0;
    else if (!spi_en_inf_system_sync) xp <= '0;
    else if (sample_valid) xp <= sample_in;
`else
  always_comb cap_d = sample_in;
`endif

  always_comb begin
    issue    = !buf_almost_wfull;
    consume  = pend_v && (state == PRIME || (state == STREAM && issue));
    rd_en    = state == REPLAY && issue;
    adv      = consume || rd_en;
    last     = cnt == ((state == STREAM) ? CW'(HOP - 1) : CW'(HIST - 1));
    take     = sample_valid && (!pend_v || consume);
    // wp always points at the oldest entry, so replay starts there and wraps
    rsum     = (CW+1)'(wp) + (CW+1)'(cnt);
    ra       = AW'((rsum >= (CW+1)'(HIST)) ? rsum - (CW+1)'(HIST) : rsum);
    state_nx = (state == IDLE) ? PRIME :
               (adv && last) ? ((state == REPLAY) ? STREAM : REPLAY) : state;
  end

  always_ff @(posedge clk)
    if (consume) ring[wp] <= pend_d;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      wp          <= '0;
      cnt         <= '0;
      pend_v      <= 1'b0;
      pend_d      <= '0;
      w_req       <= 1'b0;
      w_data      <= '0;
      frame_start <= 1'b0;
      overflow    <= 1'b0;
    end else if (!spi_en_inf_system_sync) begin
      state       <= IDLE;
      wp          <= '0;
      cnt         <= '0;
      pend_v      <= 1'b0;
      pend_d      <= '0;
      w_req       <= 1'b0;
      frame_start <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nx;
      wp          <= consume ? ((wp == AW'(HIST - 1)) ? '0 : wp + 1'b1) : wp;
      cnt         <= (adv && last) ? '0 : adv ? cnt + 1'b1 : cnt;
      pend_v      <= sample_valid || (pend_v && !consume);
      pend_d      <= take ? cap_d : pend_d;
      w_req       <= rd_en || (state == STREAM && consume);
      w_data      <= rd_en ? ring[ra] : (state == STREAM && consume) ? pend_d : w_data;
      frame_start <= rd_en && cnt == '0;
      overflow    <= overflow || (w_req && buf_wfull) || (sample_valid && pend_v && !consume);
    end
endmodule

// File: tb/tb_fft_frame_writer.sv
// tb_fft_frame_writer: directed checks of framing, backpressure, overflow, ring wrap and reset.
module tb_fft_frame_writer;
  logic clk = 0, rst_n = 0;
  logic en_a = 0, sv_a = 0, awf_a = 0, wf_a = 0, wr_a, fs_a, ov_a;
  logic en_b = 0, sv_b = 0, awf_b = 0, wf_b = 0, wr_b, fs_b, ov_b;
  logic [11:0] si_a = 0, si_b = 0, wd_a, wd_b;
  int checks = 0, errors = 0;
  int qa[$], fa[$], qb[$], fb[$];

  always #5 clk = ~clk;

  fft_frame_writer #(.N_FFT(8), .HOP(4), .DATA_WIDTH(12)) dut_a (
    .clk(clk), .rst_n(rst_n), .spi_en_inf_system_sync(en_a), .sample_valid(sv_a),
    .sample_in(si_a), .buf_almost_wfull(awf_a), .buf_wfull(wf_a), .w_req(wr_a),
    .w_data(wd_a), .frame_start(fs_a), .overflow(ov_a));

  fft_frame_writer #(.N_FFT(8), .HOP(3), .DATA_WIDTH(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .spi_en_inf_system_sync(en_b), .sample_valid(sv_b),
    .sample_in(si_b), .buf_almost_wfull(awf_b), .buf_wfull(wf_b), .w_req(wr_b),
    .w_data(wd_b), .frame_start(fs_b), .overflow(ov_b));

  always @(negedge clk) begin
    if (wr_a) begin qa.push_back(int'(wd_a)); fa.push_back(int'(fs_a)); end
    if (wr_b) begin qb.push_back(int'(wd_b)); fb.push_back(int'(fs_b)); end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_seq(input string tag, input int q[$], input int e[$]);
    check({tag, "_len"}, q.size(), e.size());
    for (int i = 0; i < e.size() && i < q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), q[i], e[i]);
  endtask

  function automatic int ones(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  task automatic send(input bit b, input int v);
    @(negedge clk);
    if (b) begin sv_b = 1; si_b = 12'(v); end else begin sv_a = 1; si_a = 12'(v); end
    @(negedge clk);
    sv_a = 0; sv_b = 0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int wcnt;
    repeat (3) @(negedge clk);
    check("rst_wreq", wr_a, 0);
    check("rst_wdata", wd_a, 0);
    check("rst_fs", fs_a, 0);
    check("rst_ov", ov_a, 0);
    rst_n = 1;
    en_a = 1;
    // ramp and frame contents
    for (int v = 1; v <= 3; v++) send(0, v);
    check("prime_nowr", qa.size(), 0);
    for (int v = 4; v <= 12; v++) send(0, v);
    repeat (10) @(negedge clk);
    check_seq("ramp", qa, '{1,2,3,4,5,6,7,8,5,6,7,8,9,10,11,12,9,10,11,12});
    check("ramp_fs_cnt", ones(fa), 3);
    if (fa.size() > 16) begin
      check("ramp_fs0", fa[0], 1);
      check("ramp_fs8", fa[8], 1);
      check("ramp_fs16", fa[16], 1);
    end
    check("ramp_ov", ov_a, 0);
    // backpressure mid-REPLAY
    @(negedge clk) en_a = 0;
    @(negedge clk) en_a = 1;
    qa.delete(); fa.delete();
    for (int v = 1; v <= 3; v++) send(0, v);
    @(negedge clk) begin sv_a = 1; si_a = 4; end
    @(negedge clk) sv_a = 0;
    repeat (2) @(negedge clk);
    check("bp_mid_wreq", wr_a, 1);
    check("bp_mid_data", wd_a, 1);
    awf_a = 1;
    wcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      wcnt += int'(wr_a);
      if (i == 8) begin sv_a = 1; si_a = 5; end
      if (i == 9) sv_a = 0;
    end
    check("bp_wreq_held", wcnt, 0);
    awf_a = 0;
    repeat (10) @(negedge clk);
    for (int v = 6; v <= 8; v++) send(0, v);
    repeat (10) @(negedge clk);
    check_seq("bp", qa, '{1,2,3,4,5,6,7,8,5,6,7,8});
    check("bp_fs_cnt", ones(fa), 2);
    // overflow
    awf_a = 1;
    send(0, 9);
    check("ov_one_ok", ov_a, 0);
    send(0, 10);
    check("ov_set", ov_a, 1);
    repeat (5) @(negedge clk);
    check("ov_sticky", ov_a, 1);
    @(negedge clk) en_a = 0;
    @(negedge clk) en_a = 1;
    awf_a = 0;
    check("ov_clear", ov_a, 0);
    check("ov_wreq", wr_a, 0);
    qa.delete(); fa.delete();
    for (int v = 1; v <= 3; v++) send(0, v);
    check("idle_reprime", qa.size(), 0);
    en_a = 0;
    // ring wrap with HIST=5
    en_b = 1;
    for (int v = 1; v <= 4; v++) send(1, v);
    check("wrap_prime", qb.size(), 0);
    for (int v = 5; v <= 13; v++) send(1, v);
    repeat (10) @(negedge clk);
    check_seq("wrap", qb, '{1,2,3,4,5,6,7,8,4,5,6,7,8,9,10,11,7,8,9,10,11,12,13});
    check("wrap_fs_cnt", ones(fb), 3);
    // reset during REPLAY
    @(negedge clk) begin sv_b = 1; si_b = 14; end
    @(negedge clk) sv_b = 0;
    repeat (2) @(negedge clk);
    check("pre_rst_fs", fs_b, 1);
    rst_n = 0;
    #1;
    check("arst_wreq", wr_b, 0);
    check("arst_fs", fs_b, 0);
    check("arst_ov", ov_b, 0);
    repeat (2) @(negedge clk);
    qb.delete(); fb.delete();
    rst_n = 1;
    for (int v = 1; v <= 4; v++) send(1, v);
    check("rst_prime", qb.size(), 0);
    send(1, 5);
    repeat (6) @(negedge clk);
    check_seq("rst_replay", qb, '{1,2,3,4,5});
    check("rst_fs_cnt", ones(fb), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_frame_writer.md
Name: fft_frame_writer

Overview:
- Write-side producer for the sample buffer that the FFT reads through r_req / buf_almost_rfull / buf_rempty.
- Takes the decimated audio sample stream and builds overlapped analysis frames of N_FFT samples each, with a hop of HOP samples.
- Each frame replays the last N_FFT-HOP samples from an internal history ring, then streams HOP new samples. Every sample is pushed into the buffer, so the FFT always receives complete, contiguous frames.

Parameters:
- N_FFT, 256, frame length in samples.
- HOP, 128, new samples per frame; legal range 1..N_FFT-1. History depth is HIST = N_FFT-HOP.
- DATA_WIDTH, 12, sample width, signed two's complement; equals the FFT input width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- spi_en_inf_system_sync  in  1  inference-system enable, already synchronised to clk.
- sample_valid  in  1  one-cycle strobe; sample_in is valid in that cycle.
- sample_in  in  DATA_WIDTH  signed audio sample.
- buf_almost_wfull  in  1  buffer has 2 or fewer free entries.
- buf_wfull  in  1  buffer full; used for the error check only.
- w_req  out  1  buffer write strobe, registered.
- w_data  out  DATA_WIDTH  write data, registered, valid when w_req=1.
- frame_start  out  1  pulse coincident with the first w_req of each frame.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; history pointer, counters and pending register cleared.
- Enable low, synchronous: forces IDLE next cycle and clears pointers, counters, pending register and overflow. Ring contents are don't-care. w_req drops the next cycle; any write already issued is not retracted.
- Write issue rule: a write (w_req=1 next cycle) is issued only when buf_almost_wfull=0 in the deciding cycle. At most one write per cycle.
- Error check: w_req=1 while buf_wfull=1 sets overflow.
- Sample input:
  - A 1-entry pending register captures sample_in on sample_valid.
  - sample_valid while pending is occupied and not consumed in the same cycle: sample dropped, overflow set.
- History ring: HIST entries, write pointer wp. Entry wp is always the oldest sample; wp wraps at HIST-1 to 0.
- FSM states:
  - IDLE: exits to PRIME when enable=1.
  - PRIME: each pending sample is written into the ring (wp++), with no buffer write. After HIST samples, go to REPLAY.
  - REPLAY: read the ring from wp for HIST consecutive entries, wrapping. Synchronous read with one cycle of latency to w_data; one entry per cycle when the issue rule allows. A stall holds the read address. Samples arriving during REPLAY wait in the pending register. After HIST writes, go to STREAM.
  - STREAM: for each pending sample, when the issue rule allows, write it to the buffer (w_data = sample, next cycle) and into ring[wp] (wp++); pending is freed. After HOP samples, go to REPLAY (next frame).
- frame_start: asserted with the first write of REPLAY.
- Latency: a pending sample in STREAM appears on w_data 1 cycle after it is consumed; with no backpressure that is 2 cycles after sample_valid.
- Simultaneous events: sample_valid in the same cycle that pending is consumed is accepted without overflow.
- Frame accounting: a frame is exactly N_FFT writes. Disabling mid-frame abandons it; the downstream FFT controller is reset by the same enable.

Optional Feature:
- Macro: FFT_FRAME_WRITER_PREEMPH_EN.
- When defined:
  - Pre-emphasis applied at pending capture: y = x - (xp - (xp >>> 5)), where xp is the previous raw sample.
  - Computed at DATA_WIDTH+2 bits, saturated to DATA_WIDTH.
  - xp resets to 0 and is cleared on disable.
  - y, not x, is stored and written. Adds no latency beyond the same capture cycle.
- When undefined: samples pass through unmodified, and no xp register is present.

Test Plan:
- Ramp and frame contents: N_FFT=8, HOP=4, enable=1, buf_almost_wfull=0, samples 1..12 every 5 cycles -> no writes for samples 1..4. Frame 1 writes 1,2,3,4,5,6,7,8 with frame_start on the write of 1. Frame 2 writes 5,6,7,8,9,10,11,12. overflow=0.
- Backpressure: as above, but buf_almost_wfull=1 for 20 cycles mid-REPLAY -> w_req=0 throughout; the sequence resumes with no gap or duplicate; one sample arriving in the window is held in pending and written later.
- Overflow: N_FFT=8, HOP=4, buf_almost_wfull=1 in STREAM, two samples arrive -> second dropped, overflow=1 and held; enable low for 1 cycle -> overflow=0, FSM in IDLE.
- Wrap: N_FFT=8, HOP=3 (HIST=5), samples 1..13 -> frames {1..8}, {4..11}. The ring pointer wraps correctly at 4->0.
- Reset mid-frame: rst_n low during REPLAY -> w_req, frame_start, overflow read 0 immediately. After release, the first 5 new samples are primed with no writes.
- FFT_FRAME_WRITER_PREEMPH_EN defined, DATA_WIDTH=12, samples 1000, 1000 -> stored 1000, then 1000-(1000-31)=31. Sample -2048 after 2047 -> saturates to -2048.
